// File: rtl/gpu_pkg.sv
// Shared TinyGPU types and constants: sequencer states and NZP flag layout.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } pc_state_t;

    localparam int unsigned NZP_BITS = 3;
    localparam int unsigned NZP_N    = 2;
    localparam int unsigned NZP_Z    = 1;
    localparam int unsigned NZP_P    = 0;

    // Flag register comes out of reset reporting "zero".
    localparam logic [NZP_BITS-1:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake plus decoder/flag-register inputs seen by the PC sequencer.
interface pc_sequencer_if
    import gpu_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8
);

    logic                 FetchReq;
    logic [ADDR_BITS-1:0] FetchAddr;
    logic                 FetchAck;
    logic                 Commit;
    logic                 PCMux;
    logic [NZP_BITS-1:0]  DecodedNZP;
    logic [ADDR_BITS-1:0] DecodedImm;
    logic                 Ret;
    logic [NZP_BITS-1:0]  NZPIn;

    modport master (
        output FetchReq, FetchAddr,
        input  FetchAck, Commit, PCMux, DecodedNZP, DecodedImm, Ret, NZPIn
    );

    modport slave (
        input  FetchReq, FetchAddr,
        output FetchAck, Commit, PCMux, DecodedNZP, DecodedImm, Ret, NZPIn
    );

endinterface

// File: rtl/pc_branch_cond.sv
// BRnzp condition: taken when the instruction is a branch and any masked flag is set.
module pc_branch_cond
    import gpu_pkg::*;
(
    input  logic [NZP_BITS-1:0] mask_i,
    input  logic [NZP_BITS-1:0] flags_i,
    input  logic                pc_mux_i,
    output logic                taken_c_o
);

    logic hit_n;
    logic hit_z;
    logic hit_p;

    assign hit_n     = mask_i[NZP_N] & flags_i[NZP_N];
    assign hit_z     = mask_i[NZP_Z] & flags_i[NZP_Z];
    assign hit_p     = mask_i[NZP_P] & flags_i[NZP_P];
    assign taken_c_o = pc_mux_i & (hit_n | hit_z | hit_p);

endmodule

// File: rtl/pc_sequencer.sv
// Per-thread PC sequencer: requests fetches at PC and picks branch target or PC+1 on commit.
module pc_sequencer
    import gpu_pkg::*;
#(
    parameter int unsigned          ADDR_BITS = 8,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = '0,
    parameter int unsigned          CNT_BITS  = 16
)(
    input  logic                  CLK,
    input  logic                  RST,
    pc_sequencer_if.master        bus,
    input  logic                  Start,
    output logic [ADDR_BITS-1:0]  PCOut,
    output logic                  BranchTaken,
    output logic                  Busy,
    output logic                  Done,
    output logic [CNT_BITS-1:0]   InstrCount
);

    pc_state_t             state_q, state_d;
    logic [ADDR_BITS-1:0]  pc_q, pc_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  bt_q, bt_d;
    logic                  taken_c;

    pc_branch_cond u_branch_cond (
        .mask_i    (bus.DecodedNZP),
        .flags_i   (bus.NZPIn),
        .pc_mux_i  (bus.PCMux),
        .taken_c_o (taken_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            bt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            bt_q    <= bt_d;
        end
    end

    // Next state, next PC and saturating commit counter; RET wins over a branch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        bt_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                if (bus.FetchAck) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (bus.Commit) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                    if (bus.Ret) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        bt_d    = taken_c;
                        pc_d    = taken_c ? bus.DecodedImm : pc_q + ADDR_BITS'(1);
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.FetchReq  = (state_q == FETCH);
    assign bus.FetchAddr = pc_q;
    assign PCOut         = pc_q;
    assign BranchTaken   = bt_q;
    assign Busy          = (state_q == FETCH) || (state_q == EXEC);
    assign Done          = (state_q == DONE);
    assign InstrCount    = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes expected fetches/snapshots, monitor compares.
module tb_pc_sequencer;
    import gpu_pkg::*;

    localparam int unsigned ADDR_BITS = 8;
    localparam int unsigned CNT_BITS  = 16;
    localparam int          PC_MOD    = 256;
    localparam int          CNT_MAX   = 65535;
    localparam int          TIMEOUT   = 20000;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 Start;
    logic [ADDR_BITS-1:0] PCOut;
    logic                 BranchTaken;
    logic                 Busy;
    logic                 Done;
    logic [CNT_BITS-1:0]  InstrCount;

    pc_sequencer_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    pc_sequencer #(
        .ADDR_BITS (ADDR_BITS),
        .RESET_PC  (8'h00),
        .CNT_BITS  (CNT_BITS)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus),
        .Start       (Start),
        .PCOut       (PCOut),
        .BranchTaken (BranchTaken),
        .Busy        (Busy),
        .Done        (Done),
        .InstrCount  (InstrCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int pc;
        int cnt;
        int bt;
    } fetch_exp_t;

    typedef struct {
        string tag;
        int    pc;
        int    req;
        int    busy;
        int    done;
        int    cnt;
        int    bt;
    } snap_t;

    fetch_exp_t fetch_q[$];
    fetch_exp_t done_q[$];
    snap_t      snap_q[$];

    int checks = 0;
    int fails  = 0;
    bit end_req = 1'b0;

    // Reference state of the thread, kept at instruction granularity.
    int m_pc  = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        snap_t      s;
        fetch_exp_t f;
        bit         prev_req;
        bit         prev_done;
        bit         req_rise;
        int         cyc;
        prev_req  = 1'b0;
        prev_done = 1'b0;
        cyc       = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk({s.tag, " PCOut"},       int'(PCOut),        s.pc);
                chk({s.tag, " FetchAddr"},   int'(bus.FetchAddr), s.pc);
                chk({s.tag, " FetchReq"},    int'(bus.FetchReq), s.req);
                chk({s.tag, " Busy"},        int'(Busy),         s.busy);
                chk({s.tag, " Done"},        int'(Done),         s.done);
                chk({s.tag, " InstrCount"},  int'(InstrCount),   s.cnt);
                chk({s.tag, " BranchTaken"}, int'(BranchTaken),  s.bt);
            end
            req_rise = bus.FetchReq && !prev_req;
            if (req_rise) begin
                if (fetch_q.size() == 0) begin
                    chk("unexpected fetch request", 1, 0);
                end else begin
                    f = fetch_q.pop_front();
                    chk("fetch FetchAddr",   int'(bus.FetchAddr), f.pc);
                    chk("fetch PCOut",       int'(PCOut),         f.pc);
                    chk("fetch InstrCount",  int'(InstrCount),    f.cnt);
                    chk("fetch BranchTaken", int'(BranchTaken),   f.bt);
                    chk("fetch Busy",        int'(Busy),          1);
                end
            end
            if (BranchTaken && !req_rise) begin
                chk("stray BranchTaken", 1, 0);
            end
            if (Done && !prev_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected Done", 1, 0);
                end else begin
                    f = done_q.pop_front();
                    chk("done PCOut",      int'(PCOut),      f.pc);
                    chk("done InstrCount", int'(InstrCount), f.cnt);
                    chk("done Busy",       int'(Busy),       0);
                end
            end
            prev_req  = bus.FetchReq;
            prev_done = Done;
            if (end_req || cyc > TIMEOUT) begin
                if (cyc > TIMEOUT) chk("timeout", 1, 0);
                chk("fetch queue drained", fetch_q.size(), 0);
                chk("done queue drained",  done_q.size(),  0);
                $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                $finish;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic snap(input string tag, input int req, input int busy, input int done, input int bt);
        snap_t s;
        s.tag  = tag;
        s.pc   = m_pc;
        s.req  = req;
        s.busy = busy;
        s.done = done;
        s.cnt  = m_cnt;
        s.bt   = bt;
        snap_q.push_back(s);
    endtask

    task automatic junk_fields();
        bus.PCMux      = 1'b1;
        bus.DecodedNZP = 3'($urandom_range(1, 7));
        bus.NZPIn      = 3'b111;
        bus.DecodedImm = 8'($urandom);
        bus.Ret        = 1'($urandom);
    endtask

    task automatic do_reset(input bit with_commit);
        RST          = 1'b1;
        Start        = 1'b0;
        bus.FetchAck = 1'b0;
        bus.Commit   = with_commit;
        junk_fields();
        tick();
        RST        = 1'b0;
        bus.Commit = 1'b0;
        m_pc       = 0;
        m_cnt      = 0;
        snap("reset", 0, 0, 0, 0);
    endtask

    task automatic do_start();
        fetch_exp_t e;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        m_pc  = 0;
        m_cnt = 0;
        e.pc = m_pc; e.cnt = m_cnt; e.bt = 0;
        fetch_q.push_back(e);
    endtask

    task automatic do_fetch(input int delay, input bit junk);
        repeat (delay) begin
            bus.Commit = junk;
            junk_fields();
            tick();
            snap("fetch wait", 1, 1, 0, 0);
        end
        bus.Commit   = 1'b0;
        bus.FetchAck = 1'b1;
        tick();
        bus.FetchAck = 1'b0;
    endtask

    task automatic do_exec(input int delay, input bit junk, input bit pcmux,
                           input logic [2:0] mask, input logic [7:0] imm,
                           input bit ret, input logic [2:0] nzp);
        fetch_exp_t e;
        bit         taken;
        repeat (delay) begin
            bus.FetchAck = junk;
            tick();
            snap("exec wait", 0, 1, 0, 0);
        end
        bus.FetchAck   = 1'b0;
        bus.Commit     = 1'b1;
        bus.PCMux      = pcmux;
        bus.DecodedNZP = mask;
        bus.DecodedImm = imm;
        bus.Ret        = ret;
        bus.NZPIn      = nzp;
        tick();
        bus.Commit = 1'b0;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (ret) begin
            e.pc = m_pc; e.cnt = m_cnt; e.bt = 0;
            done_q.push_back(e);
        end else begin
            taken = pcmux && ((int'(mask) & int'(nzp)) != 0);
            m_pc  = taken ? int'(imm) : (m_pc + 1) % PC_MOD;
            e.pc = m_pc; e.cnt = m_cnt; e.bt = int'(taken);
            fetch_q.push_back(e);
        end
    endtask

    task automatic instr(input bit pcmux, input logic [2:0] mask, input logic [7:0] imm,
                         input bit ret, input logic [2:0] nzp);
        do_fetch(0, 1'b0);
        do_exec(0, 1'b0, pcmux, mask, imm, ret, nzp);
    endtask

    initial begin : driver
        RST            = 1'b1;
        Start          = 1'b0;
        bus.FetchAck   = 1'b0;
        bus.Commit     = 1'b0;
        bus.PCMux      = 1'b0;
        bus.DecodedNZP = 3'b000;
        bus.DecodedImm = 8'h00;
        bus.Ret        = 1'b0;
        bus.NZPIn      = NZP_RESET;
        do_reset(1'b0);

        // Linear run: 0,1,2,3
        do_start();
        repeat (3) instr(1'b0, 3'b111, 8'hAA, 1'b0, 3'b111);

        // Branch to 5, taken on Z, then not taken with mask N|P
        instr(1'b1, 3'b111, 8'h05, 1'b0, 3'b111);
        instr(1'b1, 3'b010, 8'h20, 1'b0, 3'b010);
        instr(1'b1, 3'b101, 8'h40, 1'b0, 3'b010);

        // Wrap at 0xFF and empty mask
        instr(1'b1, 3'b001, 8'hFF, 1'b0, 3'b001);
        instr(1'b0, 3'b000, 8'h11, 1'b0, 3'b000);
        instr(1'b1, 3'b000, 8'h55, 1'b0, 3'b111);

        // Slow fetch with stray Commit, stray Acks during EXEC
        do_fetch(4, 1'b1);
        do_exec(3, 1'b1, 1'b1, 3'b100, 8'h90, 1'b0, 3'b100);

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            do_fetch($urandom_range(0, 3), 1'($urandom));
            do_exec($urandom_range(0, 2), 1'($urandom), 1'($urandom), 3'($urandom),
                    8'($urandom), 1'b0, 3'($urandom));
        end

        // RET beats a taken branch; Start in DONE ignored
        instr(1'b1, 3'b111, 8'h77, 1'b1, 3'b111);
        snap("after ret", 0, 0, 1, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        snap("start in done", 0, 0, 1, 0);
        tick();
        snap("done hold", 0, 0, 1, 0);

        // Reset mid-operation with Commit high
        do_reset(1'b0);
        do_start();
        instr(1'b1, 3'b010, 8'h40, 1'b0, 3'b010);
        instr(1'b0, 3'b000, 8'h00, 1'b0, 3'b000);
        do_fetch(1, 1'b0);
        do_reset(1'b1);
        tick();
        snap("idle after reset", 0, 0, 0, 0);

        repeat (3) tick();
        end_req = 1'b1;
    end

endmodule
